// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: lock FSM encoding,
// requester indices and the default RAM base address.
package ram_arbiter_pkg;

  // Ownership state of the RAM: free for arbitration or locked to one requester
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester indices used for the per-requester vectors
  localparam int REQ_CPU = 0;
  localparam int REQ_LDR = 1;

  // Byte address of RAM word 0
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage : ram_arbiter_pkg

// File: rtl/ram_addr_check.sv
// Combinational bad-address detector: flags misaligned word accesses and
// addresses outside [BASE_ADDR, BASE_ADDR + 4*MEMORY_DEPTH).
module ram_addr_check
  import ram_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  bad
);

  // Bounds carry one extra bit so BASE_ADDR + size cannot wrap to a small value
  localparam logic [ADDR_WIDTH:0] LOW_BOUND  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HIGH_BOUND = LOW_BOUND + (ADDR_WIDTH+1)'(4 * MEMORY_DEPTH);

  logic [ADDR_WIDTH:0] addr_ext;

  assign addr_ext = {1'b0, addr};

  // Any one of misalignment, below-range or at/above-end makes the access bad
  always_comb begin
    bad = (addr[1:0] != 2'b00) || (addr_ext < LOW_BOUND) || (addr_ext >= HIGH_BOUND);
  end

endmodule : ram_addr_check

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter with burst lock in front of the single-port
// data RAM. Grants are combinational; ack/err/rdata come back one cycle later.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_ack,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m0_err,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic [1:0]            req_vec;
  logic [1:0]            we_vec;
  logic [1:0]            lock_vec;
  logic [1:0]            gnt_vec;
  arb_state_t            state_reg;
  logic                  last_gnt_reg;
  logic                  sel_idx;
  logic                  any_gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic                  addr_bad;

  assign req_vec  = {m1_req,  m0_req};
  assign we_vec   = {m1_we,   m0_we};
  assign lock_vec = {m1_lock, m0_lock};

  // Grant: locked owner only, otherwise round-robin on ties; nothing during reset
  always_comb begin
    gnt_vec = 2'b00;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          if (req_vec == 2'b11) begin
            gnt_vec = last_gnt_reg ? 2'b01 : 2'b10;
          end else begin
            gnt_vec = req_vec;
          end
        end
        OWN0:    gnt_vec[REQ_CPU] = req_vec[REQ_CPU];
        OWN1:    gnt_vec[REQ_LDR] = req_vec[REQ_LDR];
        default: gnt_vec = 2'b00;
      endcase
    end
  end

  assign m0_gnt  = gnt_vec[REQ_CPU];
  assign m1_gnt  = gnt_vec[REQ_LDR];
  assign any_gnt = |gnt_vec;
  assign sel_idx = gnt_vec[REQ_LDR];

  // Steer the granted requester's access fields onto the shared path
  always_comb begin
    sel_addr  = sel_idx ? m1_addr  : m0_addr;
    sel_wdata = sel_idx ? m1_wdata : m0_wdata;
    sel_we    = sel_idx ? m1_we    : m0_we;
  end

  ram_addr_check #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .BASE_ADDR   (BASE_ADDR)
  ) u_addr_check (
    .addr(sel_addr),
    .bad (addr_bad)
  );

  // RAM drive: parked at word 0 with no write when nobody is granted
  always_comb begin
    ram_addr = BASE_ADDR;
    ram_data = '0;
    ram_we   = 1'b0;
    if (any_gnt) begin
      ram_addr = sel_addr;
      ram_data = sel_wdata;
      ram_we   = sel_we & ~addr_bad & ~reset;
    end
  end

  // Lock FSM and round-robin history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
    end else begin
      if (any_gnt) begin
        last_gnt_reg <= sel_idx;
      end
      case (state_reg)
        IDLE: begin
          if (gnt_vec[REQ_CPU] && lock_vec[REQ_CPU]) begin
            state_reg <= OWN0;
          end else if (gnt_vec[REQ_LDR] && lock_vec[REQ_LDR]) begin
            state_reg <= OWN1;
          end
        end
        OWN0:    if (!lock_vec[REQ_CPU]) state_reg <= IDLE;
        OWN1:    if (!lock_vec[REQ_LDR]) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic                  ack_reg;
      logic                  err_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;

      // One-cycle response; rdata holds between grants, zero for writes/bad reads
      always_ff @(posedge clk) begin
        if (reset) begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ack_reg <= gnt_vec[gi];
          err_reg <= gnt_vec[gi] & addr_bad;
          if (gnt_vec[gi]) begin
            rdata_reg <= (!we_vec[gi] && !addr_bad) ? ram_q : '0;
          end
        end
      end
    end
  endgenerate

  assign m0_ack   = g_resp[0].ack_reg;
  assign m0_err   = g_resp[0].err_reg;
  assign m0_rdata = g_resp[0].rdata_reg;
  assign m1_ack   = g_resp[1].ack_reg;
  assign m1_err   = g_resp[1].err_reg;
  assign m1_rdata = g_resp[1].rdata_reg;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios followed by random traffic, each
// cycle compared against a transaction-level reference model.
module tb_ram_arbiter;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  // The physical RAM attached to the arbiter: sync write, async read
  logic [DW-1:0] ram_mem [DEPTH];
  logic [31:0]   ram_off;
  logic [5:0]    ram_idx;
  assign ram_off = ram_addr - BASE;
  assign ram_idx = ram_off[7:2];
  assign ram_q   = ram_mem[ram_idx];
  always @(posedge clk) if (ram_we) ram_mem[ram_idx] <= ram_data;

  // Reference model state: memory contents, lock owner (-1 = none), last winner
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_owner = -1;
  int            m_last  = 1;
  logic [DW-1:0] m_rdata [2] = '{32'h0, 32'h0};
  int            cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  // One clock cycle: check combinational grant/RAM drive, then the registered response
  task automatic step();
    bit          rq[2], wr[2], lk[2], g[2];
    logic [31:0] ad[2], wd[2];
    bit          e_ack[2], e_err[2];
    bit          bad, exp_we;
    int          w, idx;
    longint      a;
    rq = '{m0_req, m1_req}; wr = '{m0_we, m1_we}; lk = '{m0_lock, m1_lock};
    ad = '{m0_addr, m1_addr}; wd = '{m0_wdata, m1_wdata};
    g = '{0, 0};
    if (!reset) begin
      if (m_owner >= 0)         g[m_owner] = rq[m_owner];
      else if (rq[0] && rq[1])  g[1 - m_last] = 1;
      else begin g[0] = rq[0]; g[1] = rq[1]; end
    end
    w = g[1] ? 1 : 0;
    a = longint'(ad[w]);
    bad = (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
    idx = bad ? 0 : int'((a - longint'(BASE)) / 4);
    exp_we = (g[0] || g[1]) && wr[w] && !bad;
    #1;
    chk("m0_gnt", 64'(m0_gnt), 64'(g[0]));
    chk("m1_gnt", 64'(m1_gnt), 64'(g[1]));
    chk("ram_we", 64'(ram_we), 64'(exp_we));
    chk("ram_addr", 64'(ram_addr), (g[0] || g[1]) ? 64'(ad[w]) : 64'(BASE));
    if (exp_we) chk("ram_data", 64'(ram_data), 64'(wd[w]));
    for (int k = 0; k < 2; k++) begin
      e_ack[k] = g[k];
      e_err[k] = g[k] && bad;
      if (reset)     m_rdata[k] = '0;
      else if (g[k]) m_rdata[k] = (!wr[k] && !bad) ? ref_mem[idx] : '0;
    end
    if (exp_we) ref_mem[idx] = wd[w];
    if (reset) begin
      m_owner = -1; m_last = 1;
    end else begin
      if (g[0] || g[1]) m_last = w;
      if (m_owner >= 0) begin
        if (!lk[m_owner]) m_owner = -1;
      end else if ((g[0] || g[1]) && lk[w]) begin
        m_owner = w;
      end
    end
    @(posedge clk); #1;
    chk("m0_ack", 64'(m0_ack), 64'(e_ack[0]));
    chk("m1_ack", 64'(m1_ack), 64'(e_ack[1]));
    chk("m0_err", 64'(m0_err), 64'(e_err[0]));
    chk("m1_err", 64'(m1_err), 64'(e_err[1]));
    chk("m0_rdata", 64'(m0_rdata), 64'(m_rdata[0]));
    chk("m1_rdata", 64'(m1_rdata), 64'(m_rdata[1]));
    $display("[TB] cyc=%0d rst=%0b gnt=%0b%0b we=%0b addr=%h ack=%0b%0b err=%0b%0b rd0=%h rd1=%h",
             cyc, reset, m1_gnt, m0_gnt, exp_we, ad[w], m1_ack, m0_ack, m1_err, m0_err,
             m0_rdata, m1_rdata);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return BASE + 32'($urandom_range(0, 255)) | 32'h1;
      1:       return BASE - 32'h4 * 32'($urandom_range(1, 8));
      2:       return BASE + 32'h100 + 32'h4 * 32'($urandom_range(0, 8));
      default: return BASE + 32'h4 * 32'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, BASE, 0, 0, 0, 0, BASE, 0);
    @(negedge clk);
    step(); step();
    reset = 1'b0;

    // Loader fills every RAM word so later reads have known contents
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, BASE, 0, 1, 1, 0, BASE + 32'(4 * i), $urandom);
      step();
    end

    // Fresh reset, then a simultaneous tie: m0 first, m1 next cycle
    reset = 1'b1; drive(0, 0, 0, BASE, 0, 0, 0, 0, BASE, 0); step();
    reset = 1'b0;
    drive(1, 0, 0, BASE, 0, 1, 0, 0, BASE + 4, 0); step();
    drive(0, 0, 0, BASE, 0, 1, 0, 0, BASE + 4, 0); step();
    drive(0, 0, 0, BASE, 0, 0, 0, 0, BASE, 0);     step();

    // Write then read back
    drive(1, 1, 0, BASE + 8, 32'hDEAD_BEEF, 0, 0, 0, BASE, 0); step();
    drive(1, 0, 0, BASE + 8, 0, 0, 0, 0, BASE, 0);             step();

    // m1 locked burst of three while m0 waits; m0 wins once lock drops
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, BASE + 12, 0, 1, 1, 1, BASE + 32'(16 + 4 * i), 32'(i));
      step();
    end
    drive(1, 0, 0, BASE + 12, 0, 0, 0, 0, BASE, 0); step();
    drive(1, 0, 0, BASE + 12, 0, 0, 0, 0, BASE, 0); step();

    // Boundary and illegal addresses
    drive(1, 0, 0, BASE + 32'hFC, 0, 0, 0, 0, BASE, 0);        step();
    drive(1, 0, 0, BASE + 32'h100, 0, 0, 0, 0, BASE, 0);       step();
    drive(1, 1, 0, BASE + 32'h100, 32'h55, 0, 0, 0, BASE, 0);  step();
    drive(0, 0, 0, BASE, 0, 1, 1, 0, BASE + 2, 32'h66);        step();
    drive(0, 0, 0, BASE, 0, 1, 0, 0, BASE + 2, 0);             step();
    drive(1, 0, 0, 32'h1000_FFFC, 0, 0, 0, 0, BASE, 0);        step();
    drive(1, 1, 0, 32'h1000_FFFC, 32'h77, 0, 0, 0, BASE, 0);   step();

    // Reset lands on a write: nothing written, responses cleared
    reset = 1'b1; drive(1, 1, 0, BASE + 32'h10, 32'h1234, 0, 0, 0, BASE, 0); step();
    reset = 1'b0; drive(1, 0, 0, BASE + 32'h10, 0, 0, 0, 0, BASE, 0);        step();

    // Continuous requests from both: strict alternation
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, BASE + 32'(4 * i), 0, 1, 0, 0, BASE + 32'(4 * (i + 8)), 0);
      step();
    end

    // Random traffic with occasional locks, bad addresses and resets
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0, rand_addr(), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) == 0, rand_addr(), $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ram_arbiter
